adc_scan_sequencer: RTL and testbench
=====================================

# adc_scan_sequencer

Multi-channel scan controller sitting between the ADC register wrapper and the SAR conversion controller. It steps an external analog mux through the enabled channels and waits a programmable settle time after each switch. It then issues a one-cycle start-of-conversion pulse and waits for end-of-conversion. Each result is tagged with its channel number and pushed into a first-word-fall-through result FIFO that software drains over Wishbone.

## Interface
- NCH, 4, number of mux channels (2..16); CHW = $clog2(NCH)
- DW, 12, conversion data width
- DEPTH, 8, result FIFO depth (power of two); LW = $clog2(DEPTH)+1
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- enable  in  1  sequencer enable; low forces IDLE
- start  in  1  single-cycle pulse, begins one scan
- continuous  in  1  restart scan automatically after completion
- ch_mask  in  NCH  channels included in scan (bit i = channel i)
- settle_cfg  in  8  settle cycles after each mux change
- mux_sel  out  CHW  analog mux select
- soc  out  1  one-cycle start-of-conversion to SAR controller
- eoc  in  1  one-cycle end-of-conversion from SAR controller
- sar_data  in  DW  conversion result, valid when eoc=1
- fifo_rd  in  1  pop head entry
- fifo_dout  out  CHW+DW  head entry {channel, data}
- fifo_empty / fifo_full  out  1  FIFO status
- fifo_level  out  LW  entry count 0..DEPTH
- busy  out  1  high in any state except IDLE
- scan_done  out  1  one-cycle pulse when last enabled channel stored
- overrun  out  1  sticky, set when a result is dropped on full FIFO
- ovr_clr  in  1  clears overrun

## Operation
- States: IDLE, SETTLE, CONVERT, STORE.
- IDLE: on start=1 with enable=1 and ch_mask!=0, load mux_sel with the lowest set ch_mask bit and load settle counter=settle_cfg, then go to SETTLE. A start with ch_mask==0 or enable=0 is ignored.
- SETTLE: decrement counter. At 0, assert soc for one cycle and go to CONVERT. With settle_cfg=0, soc fires the cycle after entering SETTLE.
- CONVERT: wait for eoc. On eoc, latch sar_data and go to STORE.
- STORE: push {mux_sel, latched data}. If fifo_full and fifo_rd=0, drop the result and set overrun. Next channel is the next higher set bit of ch_mask, using ch_mask as sampled at scan start.
  - If a next channel exists: load mux_sel, reload the counter, go to SETTLE.
  - If none: pulse scan_done. If continuous=1, restart from the lowest channel (SETTLE). Otherwise go to IDLE.
- start while busy: ignored.
- enable deassert in any state: IDLE on next edge. No push happens; FIFO contents are kept; mux_sel holds.
- FIFO: simultaneous push+pop when full gives level unchanged and no overrun. Pop when empty is ignored, and level does not underflow. Push+pop when empty gives level 1, and the pushed entry is visible at the head.
- ovr_clr and overrun set in the same cycle: set wins.

## Timing
- Reset values: mux_sel=0, soc=0, busy=0, scan_done=0, overrun=0, fifo_empty=1, fifo_full=0, fifo_level=0, fifo_dout=0, FSM=IDLE.
- Latency from start sampled at edge N: busy=1 and mux_sel valid at N+1. soc high during cycle N+1+settle_cfg.
- eoc sampled at edge M: entry written at edge M+1 and visible on fifo_dout/fifo_level from M+1 onward (STORE occupies one cycle).
- After a store, next channel's mux_sel is valid at M+2.
- fifo_dout is combinational from the head pointer (FWFT). fifo_rd advances the head at the sampling edge.
- All outputs are registered except fifo_dout.

## Configuration
- ADC_SEQ_AVG_EN defined: each channel is converted 4 times back-to-back. Settle happens only before the first conversion; soc is reissued the cycle after each eoc. Results accumulate in a DW+2 bit register, and the stored value is acc[DW+1:2] (truncated mean). One FIFO entry is written per channel.
- ADC_SEQ_AVG_EN undefined: one conversion per channel, result stored unmodified. No accumulator logic.

## Test plan
- ch_mask=4'b1010, settle_cfg=3, start; eoc returns 0x123 then 0xABC: mux_sel=1 then 3. soc occurs 4 cycles after each mux change. FIFO holds {1,0x123},{3,0xABC}. One scan_done pulse, then IDLE.
- continuous=1, ch_mask=4'b0001, no reads, DEPTH=8: after 8 stores fifo_full=1; the 9th result sets overrun; level stays 8. ovr_clr clears overrun.
- Full FIFO with fifo_rd=1 in the STORE cycle: level stays 8, overrun stays 0, head advances.
- enable dropped while in CONVERT, then a late eoc: FSM goes to IDLE, busy=0, no FIFO push, level unchanged.
- ch_mask=0 with start, and start while busy: no soc, no state change.
- With ADC_SEQ_AVG_EN, eoc data 100,101,102,103 on channel 2: 4 soc pulses, single entry {2,101}.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// Multi-channel ADC scan sequencer: mux stepping, settle timing, SOC/EOC handshake and a FWFT result FIFO.
// Define ADC_SEQ_AVG_EN to average four back-to-back conversions per channel.
module adc_scan_sequencer #(
  parameter int NCH = 4,
  parameter int DW = 12,
  parameter int DEPTH = 8,
  localparam int CHW = $clog2(NCH),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                enable,
  input  logic                start,
  input  logic                continuous,
  input  logic [NCH-1:0]      ch_mask,
  input  logic [7:0]          settle_cfg,
  output logic [CHW-1:0]      mux_sel,
  output logic                soc,
  input  logic                eoc,
  input  logic [DW-1:0]       sar_data,
  input  logic                fifo_rd,
  output logic [CHW+DW-1:0]   fifo_dout,
  output logic                fifo_empty,
  output logic                fifo_full,
  output logic [LW-1:0]       fifo_level,
  output logic                busy,
  output logic                scan_done,
  output logic                overrun,
  input  logic                ovr_clr
);
  localparam int AW = LW - 1;

  typedef enum logic [1:0] {IDLE, SETTLE, CONVERT, STORE} state_t;

  state_t          state_reg, state_next;
  logic [CHW-1:0]  mux_sel_reg, mux_sel_next;
  logic [7:0]      cnt_reg, cnt_next;
  logic [NCH-1:0]  mask_reg, mask_next;
  logic [DW-1:0]   data_reg, data_next;
  logic            soc_reg, soc_next;
  logic            done_reg, done_next;
  logic            busy_reg;
  logic            push;

  logic [CHW-1:0]  first_ch, restart_ch, next_ch;
  logic            next_found;

`ifdef ADC_SEQ_AVG_EN
  logic [DW+1:0]   acc_reg, acc_next, sum;
  logic [1:0]      conv_reg, conv_next;
  assign sum = acc_reg + {2'b00, sar_data};
`endif

  // Channel pickers: lowest bit of the live mask (scan start), lowest bit of the
  // latched mask (continuous restart) and next higher latched bit above mux_sel.
  always_comb begin
    first_ch   = '0;
    restart_ch = '0;
    next_ch    = '0;
    next_found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_mask[i])  first_ch   = CHW'(i);
      if (mask_reg[i]) restart_ch = CHW'(i);
      if (mask_reg[i] && (i > int'(mux_sel_reg))) begin
        next_ch    = CHW'(i);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    mux_sel_next = mux_sel_reg;
    cnt_next     = cnt_reg;
    mask_next    = mask_reg;
    data_next    = data_reg;
    soc_next     = 1'b0;
    done_next    = 1'b0;
    push         = 1'b0;
`ifdef ADC_SEQ_AVG_EN
    acc_next     = acc_reg;
    conv_next    = conv_reg;
`endif
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && (|ch_mask)) begin
            mask_next    = ch_mask;
            mux_sel_next = first_ch;
            cnt_next     = settle_cfg;
            state_next   = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_reg == 8'd0) begin
            soc_next   = 1'b1;
            state_next = CONVERT;
`ifdef ADC_SEQ_AVG_EN
            acc_next   = '0;
            conv_next  = '0;
`endif
          end else begin
            cnt_next = cnt_reg - 8'd1;
          end
        end
        CONVERT: begin
          if (eoc) begin
`ifdef ADC_SEQ_AVG_EN
            if (conv_reg == 2'd3) begin
              data_next  = sum[DW+1:2];
              state_next = STORE;
            end else begin
              acc_next  = sum;
              conv_next = conv_reg + 2'd1;
              soc_next  = 1'b1;
            end
`else
            data_next  = sar_data;
            state_next = STORE;
`endif
          end
        end
        STORE: begin
          push     = 1'b1;
          cnt_next = settle_cfg;
          if (next_found) begin
            mux_sel_next = next_ch;
            state_next   = SETTLE;
          end else begin
            done_next = 1'b1;
            if (continuous) begin
              mux_sel_next = restart_ch;
              state_next   = SETTLE;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg   <= IDLE;
      mux_sel_reg <= '0;
      cnt_reg     <= '0;
      mask_reg    <= '0;
      data_reg    <= '0;
      soc_reg     <= 1'b0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
`ifdef ADC_SEQ_AVG_EN
      acc_reg     <= '0;
      conv_reg    <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      mux_sel_reg <= mux_sel_next;
      cnt_reg     <= cnt_next;
      mask_reg    <= mask_next;
      data_reg    <= data_next;
      soc_reg     <= soc_next;
      done_reg    <= done_next;
      busy_reg    <= (state_next != IDLE);
`ifdef ADC_SEQ_AVG_EN
      acc_reg     <= acc_next;
      conv_reg    <= conv_next;
`endif
    end
  end

  // Result FIFO. A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  logic [CHW+DW-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]     level_reg, level_next;
  logic              empty_reg, full_reg, overrun_reg;
  logic              push_en, pop_en, drop;

  assign push_en = push && (!full_reg || fifo_rd);
  assign pop_en  = fifo_rd && !empty_reg;
  assign drop    = push && full_reg && !fifo_rd;

  always_comb begin
    level_next = level_reg;
    if (push_en && !pop_en)      level_next = level_reg + LW'(1);
    else if (pop_en && !push_en) level_next = level_reg - LW'(1);
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_en) mem[wr_ptr_reg] <= {mux_sel_reg, data_reg};
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      empty_reg   <= 1'b1;
      full_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_next;
      empty_reg <= (level_next == '0);
      full_reg  <= (level_next == LW'(DEPTH));
      if (drop)         overrun_reg <= 1'b1;
      else if (ovr_clr) overrun_reg <= 1'b0;
    end
  end

  assign fifo_dout  = empty_reg ? '0 : mem[rd_ptr_reg];
  assign fifo_empty = empty_reg;
  assign fifo_full  = full_reg;
  assign fifo_level = level_reg;
  assign overrun    = overrun_reg;
  assign mux_sel    = mux_sel_reg;
  assign soc        = soc_reg;
  assign busy       = busy_reg;
  assign scan_done  = done_reg;
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed self-checking bench for adc_scan_sequencer (NCH=4, DW=12, DEPTH=8).
module tb_adc_scan_sequencer;
  localparam int NCH = 4;
  localparam int DW = 12;
  localparam int DEPTH = 8;
  localparam int CHW = 2;
  localparam int LW = 4;
`ifdef ADC_SEQ_AVG_EN
  localparam int NCONV = 4;
`else
  localparam int NCONV = 1;
`endif

  logic               wb_clk_i = 1'b0;
  logic               wb_rst_i = 1'b1;
  logic               enable = 1'b0, start = 1'b0, continuous = 1'b0;
  logic [NCH-1:0]     ch_mask = '0;
  logic [7:0]         settle_cfg = '0;
  logic [CHW-1:0]     mux_sel;
  logic               soc, eoc = 1'b0;
  logic [DW-1:0]      sar_data = '0;
  logic               fifo_rd = 1'b0, ovr_clr = 1'b0;
  logic [CHW+DW-1:0]  fifo_dout;
  logic               fifo_empty, fifo_full, busy, scan_done, overrun;
  logic [LW-1:0]      fifo_level;

  int checks = 0;
  int errors = 0;

  adc_scan_sequencer #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .enable(enable), .start(start),
    .continuous(continuous), .ch_mask(ch_mask), .settle_cfg(settle_cfg),
    .mux_sel(mux_sel), .soc(soc), .eoc(eoc), .sar_data(sar_data),
    .fifo_rd(fifo_rd), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_level(fifo_level), .busy(busy),
    .scan_done(scan_done), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick;
    @(posedge wb_clk_i);
    #1;
  endtask

  // Number of edges until soc is seen high; -1 when it never appears.
  task automatic wait_soc(output int n);
    n = 0;
    while (soc !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
    if (soc !== 1'b1) n = -1;
  endtask

  task automatic do_conv(input logic [DW-1:0] d);
    for (int k = 0; k < NCONV; k++) begin
      eoc = 1'b1;
      sar_data = d;
      tick;
      eoc = 1'b0;
    end
  endtask

  task automatic test_reset;
    tick;
    tick;
    checks++;
    if ({mux_sel, soc, busy, scan_done, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got mux=%0d soc=%0b busy=%0b done=%0b ovr=%0b want all 0",
               mux_sel, soc, busy, scan_done, overrun);
    end
    checks++;
    if ({fifo_empty, fifo_full, fifo_level, fifo_dout} !== {1'b1, 1'b0, 4'd0, 14'd0}) begin
      errors++;
      $display("FAIL reset_fifo got empty=%0b full=%0b level=%0d dout=%h want 1 0 0 0",
               fifo_empty, fifo_full, fifo_level, fifo_dout);
    end
    wb_rst_i = 1'b0;
    tick;
    $display("reset released");
  endtask

  task automatic test_basic_scan;
    int n;
    ch_mask = 4'b1010; settle_cfg = 8'd3; continuous = 1'b0; enable = 1'b1;
    start = 1'b1; tick; start = 1'b0;
    checks++;
    if ({busy, mux_sel, soc} !== {1'b1, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL basic_start got busy=%0b mux=%0d soc=%0b want 1 1 0", busy, mux_sel, soc);
    end
    wait_soc(n);
    checks++;
    if (n != 4) begin errors++; $display("FAIL basic_soc1_delay got %0d want 4", n); end
    do_conv(12'h123); tick;
    checks++;
    if ({fifo_level, fifo_dout, mux_sel, busy, scan_done} !== {4'd1, 2'd1, 12'h123, 2'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL basic_store1 got level=%0d dout=%h mux=%0d busy=%0b done=%0b want 1 1123 3 1 0",
               fifo_level, fifo_dout, mux_sel, busy, scan_done);
    end
    wait_soc(n);
    checks++;
    if (n != 4) begin errors++; $display("FAIL basic_soc2_delay got %0d want 4", n); end
    do_conv(12'hABC); tick;
    checks++;
    if ({scan_done, busy, fifo_level} !== {1'b1, 1'b0, 4'd2}) begin
      errors++;
      $display("FAIL basic_done got done=%0b busy=%0b level=%0d want 1 0 2", scan_done, busy, fifo_level);
    end
    tick;
    checks++;
    if ({scan_done, soc, fifo_dout} !== {1'b0, 1'b0, 2'd1, 12'h123}) begin
      errors++;
      $display("FAIL basic_idle got done=%0b soc=%0b dout=%h want 0 0 1123", scan_done, soc, fifo_dout);
    end
    fifo_rd = 1'b1; tick; fifo_rd = 1'b0;
    checks++;
    if ({fifo_dout, fifo_level} !== {2'd3, 12'hABC, 4'd1}) begin
      errors++;
      $display("FAIL basic_pop1 got dout=%h level=%0d want 3abc 1", fifo_dout, fifo_level);
    end
    fifo_rd = 1'b1; tick; fifo_rd = 1'b0;
    checks++;
    if ({fifo_empty, fifo_level, fifo_dout} !== {1'b1, 4'd0, 14'd0}) begin
      errors++;
      $display("FAIL basic_pop2 got empty=%0b level=%0d dout=%h want 1 0 0", fifo_empty, fifo_level, fifo_dout);
    end
    $display("basic scan done");
  endtask

  task automatic test_overrun;
    int n;
    ch_mask = 4'b0001; settle_cfg = 8'd0; continuous = 1'b1;
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wait_soc(n);
      checks++;
      if (n < 0) begin errors++; $display("FAIL ovr_soc_timeout store %0d got none want soc", i); end
      do_conv(12'h100 + 12'(i)); tick;
      if (i == 7) begin
        checks++;
        if ({fifo_full, fifo_level, overrun} !== {1'b1, 4'd8, 1'b0}) begin
          errors++;
          $display("FAIL ovr_full got full=%0b level=%0d ovr=%0b want 1 8 0", fifo_full, fifo_level, overrun);
        end
      end
    end
    checks++;
    if ({overrun, fifo_full, fifo_level, fifo_dout} !== {1'b1, 1'b1, 4'd8, 2'd0, 12'h100}) begin
      errors++;
      $display("FAIL ovr_drop got ovr=%0b full=%0b level=%0d dout=%h want 1 1 8 0100",
               overrun, fifo_full, fifo_level, fifo_dout);
    end
    ovr_clr = 1'b1; tick; ovr_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %0b want 0", overrun); end
    $display("overrun scenario done");
  endtask

  task automatic test_full_pop;
    int n;
    wait_soc(n);
    do_conv(12'h055);
    fifo_rd = 1'b1; tick; fifo_rd = 1'b0;
    checks++;
    if ({fifo_level, overrun, fifo_full, fifo_dout} !== {4'd8, 1'b0, 1'b1, 2'd0, 12'h101}) begin
      errors++;
      $display("FAIL full_pop got level=%0d ovr=%0b full=%0b dout=%h want 8 0 1 0101",
               fifo_level, overrun, fifo_full, fifo_dout);
    end
    $display("full push+pop done");
  endtask

  task automatic test_enable_drop;
    int n;
    logic [DW-1:0] exp_d;
    wait_soc(n);
    enable = 1'b0; tick;
    checks++;
    if ({busy, soc} !== 2'b00) begin
      errors++;
      $display("FAIL en_drop got busy=%0b soc=%0b want 0 0", busy, soc);
    end
    enable = 1'b1; continuous = 1'b0;
    eoc = 1'b1; sar_data = 12'hFFF; tick; eoc = 1'b0; tick;
    checks++;
    if ({busy, fifo_level, fifo_dout} !== {1'b0, 4'd8, 2'd0, 12'h101}) begin
      errors++;
      $display("FAIL en_late_eoc got busy=%0b level=%0d dout=%h want 0 8 0101", busy, fifo_level, fifo_dout);
    end
    for (int i = 0; i < 8; i++) begin
      exp_d = (i < 7) ? 12'h101 + 12'(i) : 12'h055;
      checks++;
      if (fifo_dout !== {2'd0, exp_d}) begin
        errors++;
        $display("FAIL drain_%0d got %h want %h", i, fifo_dout, {2'd0, exp_d});
      end
      fifo_rd = 1'b1; tick; fifo_rd = 1'b0;
    end
    fifo_rd = 1'b1; tick; fifo_rd = 1'b0;
    checks++;
    if ({fifo_empty, fifo_level} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL empty_pop got empty=%0b level=%0d want 1 0", fifo_empty, fifo_level);
    end
    $display("enable drop and drain done");
  endtask

  task automatic test_ignored_start;
    int n, socs;
    ch_mask = 4'b0000; settle_cfg = 8'd0;
    start = 1'b1; tick; start = 1'b0;
    socs = 0;
    for (int i = 0; i < 5; i++) begin
      if (soc === 1'b1) socs++;
      tick;
    end
    checks++;
    if ({busy, 3'(socs)} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL mask0_start got busy=%0b socs=%0d want 0 0", busy, socs);
    end
    enable = 1'b0; ch_mask = 4'b0100;
    start = 1'b1; tick; start = 1'b0; tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL disabled_start got busy=%0b want 0", busy); end
    enable = 1'b1; settle_cfg = 8'd5;
    start = 1'b1; tick; start = 1'b0;
    ch_mask = 4'b0001;
    start = 1'b1; tick; start = 1'b0;
    checks++;
    if ({busy, mux_sel, soc} !== {1'b1, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL busy_start got busy=%0b mux=%0d soc=%0b want 1 2 0", busy, mux_sel, soc);
    end
    wait_soc(n);
    checks++;
    if (n != 5) begin errors++; $display("FAIL busy_start_soc got %0d want 5", n); end
    do_conv(12'h7FF);
    fifo_rd = 1'b1; tick; fifo_rd = 1'b0;
    checks++;
    if ({scan_done, busy, fifo_level, fifo_dout} !== {1'b1, 1'b0, 4'd1, 2'd2, 12'h7FF}) begin
      errors++;
      $display("FAIL empty_push_pop got done=%0b busy=%0b level=%0d dout=%h want 1 0 1 27ff",
               scan_done, busy, fifo_level, fifo_dout);
    end
    fifo_rd = 1'b1; tick; fifo_rd = 1'b0;
    $display("ignored start cases done");
  endtask

`ifdef ADC_SEQ_AVG_EN
  task automatic test_avg;
    int n, socs;
    ch_mask = 4'b0100; settle_cfg = 8'd1; continuous = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    socs = 0;
    for (int k = 0; k < 4; k++) begin
      wait_soc(n);
      if (n >= 0) socs++;
      eoc = 1'b1; sar_data = 12'(100 + k); tick; eoc = 1'b0;
    end
    tick;
    checks++;
    if ({3'(socs), fifo_level, fifo_dout} !== {3'd4, 4'd1, 2'd2, 12'd101}) begin
      errors++;
      $display("FAIL avg got socs=%0d level=%0d dout=%h want 4 1 2065", socs, fifo_level, fifo_dout);
    end
    $display("averaging done");
  endtask
`endif

  initial begin
    test_reset;
    test_basic_scan;
    test_overrun;
    test_full_pop;
    test_enable_drop;
    test_ignored_start;
`ifdef ADC_SEQ_AVG_EN
    test_avg;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
